// File: rtl/inv_mix_columns_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : inv_mix_columns_seq_if
//  Purpose  : Handshake bundle for the sequential InvMixColumns engine.
//             Input side  : valid_i / ready_o / state_i (+ mode_i when the
//                           INV_MIX_FWD_MODE_EN macro is defined)
//             Output side : valid_o / ready_i / state_o
//             slave  modport : the engine
//             master modport : the producer/consumer driving the engine
//  Revision : 1.0 - initial release
// ============================================================================
interface inv_mix_columns_seq_if #(
    parameter int COLS = 4
);
    logic                 valid_i;
    logic                 ready_o;
    logic [32*COLS-1:0]   state_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [32*COLS-1:0]   state_o;
`ifdef INV_MIX_FWD_MODE_EN
    logic                 mode_i;
`endif

    modport slave (
`ifdef INV_MIX_FWD_MODE_EN
        input  mode_i,
`endif
        input  valid_i,
        input  state_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output state_o
    );

    modport master (
`ifdef INV_MIX_FWD_MODE_EN
        output mode_i,
`endif
        output valid_i,
        output state_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  state_o
    );
endinterface
`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module   : inv_mix_columns_seq
//  Purpose  : AES InvMixColumns over GF(2^8) (x^8+x^4+x^3+x+1), one column
//             per cycle through a single shared column multiplier.
//             IDLE accepts a state, CALC writes one result column per cycle,
//             DONE holds the result until the consumer takes it.
//  Ports    : clk_i  - clock, rising edge
//             rst_i  - synchronous reset, active-high
//             bus    - inv_mix_columns_seq_if.slave (valid/ready in and out,
//                      state_i / state_o with byte k at [SW-1-8k -: 8])
//  Config   : INV_MIX_FWD_MODE_EN - when defined, bus.mode_i is latched on
//             accept; 1 selects the forward MixColumns matrix instead.
//  Revision : 1.0 - initial release
// ============================================================================
module inv_mix_columns_seq #(
    parameter int WIDTH = 8,    // byte width; only 8 is supported
    parameter int COLS  = 4
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    inv_mix_columns_seq_if.slave bus
);
    localparam int COL_W = 4 * WIDTH;
    localparam int SW    = COL_W * COLS;
    localparam int CNT_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   col_cnt_q, col_cnt_d;
    logic [SW-1:0]      in_q,      in_d;
    logic [SW-1:0]      res_q,     res_d;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;
    logic               fwd_sel;

`ifdef INV_MIX_FWD_MODE_EN
    logic               mode_q,    mode_d;
    assign fwd_sel = mode_q;
`else
    assign fwd_sel = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // All multiples come from one xtime chain per byte; the forward matrix
    // reuses the x2 term so both modes share the same multiplier.
    function automatic logic [31:0] mix_col(input logic [31:0] a, input logic fwd);
        logic [7:0] b   [4];
        logic [7:0] m2  [4];
        logic [7:0] m3  [4];
        logic [7:0] m9  [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x4, x8;
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            b[2'(k)]   = a[31-8*k -: 8];
            m2[2'(k)]  = xtime(b[2'(k)]);
            x4         = xtime(m2[2'(k)]);
            x8         = xtime(x4);
            m3[2'(k)]  = m2[2'(k)] ^ b[2'(k)];
            m9[2'(k)]  = x8 ^ b[2'(k)];
            m11[2'(k)] = x8 ^ m2[2'(k)] ^ b[2'(k)];
            m13[2'(k)] = x8 ^ x4 ^ b[2'(k)];
            m14[2'(k)] = x8 ^ x4 ^ m2[2'(k)];
        end
        // Both matrices are circulant: row i uses byte i with the leading
        // coefficient and the remaining bytes rotated behind it.
        for (int i = 0; i < 4; i++) begin
            if (fwd)
                r[31-8*i -: 8] = m2[2'(i)] ^ m3[2'(i+1)] ^ b[2'(i+2)] ^ b[2'(i+3)];
            else
                r[31-8*i -: 8] = m14[2'(i)] ^ m11[2'(i+1)] ^ m13[2'(i+2)] ^ m9[2'(i+3)];
        end
        return r;
    endfunction

    // Column select from the latched input and the shared multiplier.
    always_comb begin
        col_in = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_cnt_q == CNT_W'(c))
                col_in = in_q[SW-1-COL_W*c -: COL_W];
        end
        col_out = mix_col(col_in, fwd_sel);
    end

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        in_d      = in_q;
        res_d     = res_q;
`ifdef INV_MIX_FWD_MODE_EN
        mode_d    = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.valid_i) begin
                    in_d      = bus.state_i;
                    col_cnt_d = '0;
`ifdef INV_MIX_FWD_MODE_EN
                    mode_d    = bus.mode_i;
`endif
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                for (int c = 0; c < COLS; c++) begin
                    if (col_cnt_q == CNT_W'(c))
                        res_d[SW-1-COL_W*c -: COL_W] = col_out;
                end
                col_cnt_d = col_cnt_q + 1'b1;
                if (col_cnt_q == LAST_COL)
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (bus.ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            col_cnt_q <= '0;
            in_q      <= '0;
            res_q     <= '0;
`ifdef INV_MIX_FWD_MODE_EN
            mode_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            in_q      <= in_d;
            res_q     <= res_d;
`ifdef INV_MIX_FWD_MODE_EN
            mode_q    <= mode_d;
`endif
        end
    end

    assign bus.ready_o = (state_q == S_IDLE);
    assign bus.valid_o = (state_q == S_DONE);
    assign bus.state_o = res_q;

endmodule
`default_nettype wire
